// File: rtl/imem_loader.sv
// Byte-stream boot loader: receives a length-prefixed program image and writes it word by word into
// instruction memory while holding the CPU in reset. Optional trailing XOR checksum via IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
    localparam state_t S_AFTER_DATA = S_CSUM;
`else
    typedef enum logic [2:0] {S_LEN_LO, S_LEN_HI, S_DATA, S_DONE, S_ERR} state_t;
    localparam state_t S_AFTER_DATA = S_DONE;
`endif

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t      state, state_next;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [15:0] len_full;
    logic [1:0]  byte_pos;
    logic [16:0] word_idx;
    logic [23:0] word_buf;
    logic        accepting;
    logic        xfer;
    logic        last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign accepting = (state != S_DONE) && (state != S_ERR);
    assign in_ready  = accepting;
    assign xfer      = in_valid && accepting;
    assign len_full  = {in_data, len_lo};
    assign last_word = ((word_idx + 17'd1) == {1'b0, len});
    assign cpu_hold  = (state != S_DONE);
    assign done      = (state == S_DONE);
    assign error     = (state == S_ERR);

    always_comb begin
        state_next = state;
        case (state)
            S_LEN_LO: if (xfer) state_next = S_LEN_HI;
            S_LEN_HI: begin
                if (xfer) begin
                    if ({1'b0, len_full} > DEPTH_L)
                        state_next = S_ERR;
                    else if (len_full == 16'd0)
                        state_next = S_AFTER_DATA;
                    else
                        state_next = S_DATA;
                end
            end
            S_DATA: if (xfer && byte_pos == 2'd3 && last_word) state_next = S_AFTER_DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: if (xfer) state_next = (in_data == csum) ? S_DONE : S_ERR;
`endif
            default: state_next = state;
        endcase
    end

    // Control path: state, counters, write strobe and address; reset abandons any load in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_LEN_LO;
            byte_pos  <= 2'd0;
            word_idx  <= 17'd0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= 32'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum      <= 8'd0;
`endif
        end else begin
            state  <= state_next;
            mem_we <= 1'b0;
            if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (state != S_CSUM) csum <= csum ^ in_data;
`endif
                if (state == S_LEN_HI) begin
                    byte_pos <= 2'd0;
                    word_idx <= 17'd0;
                end
                if (state == S_DATA) begin
                    byte_pos <= byte_pos + 2'd1;
                    if (byte_pos == 2'd3) begin
                        mem_we    <= 1'b1;
                        mem_wdata <= {in_data, word_buf};
                        mem_addr  <= word_idx[ADDR_W-1:0];
                        word_idx  <= word_idx + 17'd1;
                    end
                end
            end
        end
    end

    // Data path: length bytes and partial word, always overwritten before use
    always_ff @(posedge clk) begin
        if (xfer) begin
            if (state == S_LEN_LO) len_lo <= in_data;
            if (state == S_LEN_HI) len <= len_full;
            if (state == S_DATA) begin
                case (byte_pos)
                    2'd0:    word_buf[7:0]   <= in_data;
                    2'd1:    word_buf[15:8]  <= in_data;
                    2'd2:    word_buf[23:16] <= in_data;
                    default: word_buf        <= word_buf;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as streams are driven and
// popped when mem_we is observed. Builds with or without IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'd0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;

    imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          wr_count = 0;
    bit          gap_en   = 1'b0;
    logic [41:0] exp_q[$];
    logic [41:0] mon_e;
    logic [7:0]  s[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_write", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_eq("wr_addr", 64'(mem_addr), 64'(mon_e[41:32]));
                check_eq("wr_data", 64'(mem_wdata), 64'(mon_e[31:0]));
            end
        end
    end

    task automatic expect_word(input logic [9:0] addr, input logic [31:0] data);
        exp_q.push_back({addr, data});
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        if (gap_en) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                in_data = 8'($urandom);
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) check_eq("ready_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_load(input logic [7:0] bytes[$], input bit add_csum);
        logic [7:0] x;
        x = 8'd0;
        foreach (bytes[i]) begin
            x ^= bytes[i];
            send_byte(bytes[i]);
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (add_csum) send_byte(x);
`else
        if (add_csum) x = 8'd0;
`endif
    endtask

    task automatic do_reset(input bit hold_valid);
        reset    = 1'b1;
        in_valid = hold_valid;
        in_data  = 8'($urandom);
        @(posedge clk); #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        wr_count = 0;
        exp_q.delete();
    endtask

    task automatic check_reset_state();
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("rst_mem_we", 64'(mem_we), 64'd0);
        check_eq("rst_mem_addr", 64'(mem_addr), 64'd0);
        check_eq("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check_eq("rst_cpu_hold", 64'(cpu_hold), 64'd1);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_error", 64'(error), 64'd0);
    endtask

    task automatic check_final(input bit exp_done, input bit exp_err, input int exp_writes);
        repeat (3) @(posedge clk);
        #1;
        check_eq("fin_done", 64'(done), 64'(exp_done));
        check_eq("fin_error", 64'(error), 64'(exp_err));
        check_eq("fin_cpu_hold", 64'(cpu_hold), 64'(!exp_done));
        check_eq("fin_in_ready", 64'(in_ready), 64'd0);
        check_eq("fin_pending_writes", 64'(exp_q.size()), 64'd0);
        check_eq("fin_write_count", 64'(wr_count), 64'(exp_writes));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        repeat (2) @(posedge clk);
        #1;
        do_reset(1'b0);
        check_reset_state();

        // Two-word program
        expect_word(10'd0, 32'h0010_0513);
        expect_word(10'd1, 32'h0020_0593);
        s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        send_load(s, 1'b1);
        check_final(1'b1, 1'b0, 2);

        // Reset with a byte offered must leave clean reset state
        do_reset(1'b1);
        check_reset_state();

        // Length one past DEPTH
        s = '{8'h01, 8'h04};
        send_load(s, 1'b0);
        check_final(1'b0, 1'b1, 0);

        // Zero-length image
        do_reset(1'b0);
        s = '{8'h00, 8'h00};
        send_load(s, 1'b1);
        check_final(1'b1, 1'b0, 0);

        // Abandoned load followed by a fresh one
        do_reset(1'b0);
        s = '{8'h01, 8'h00, 8'h13, 8'h05};
        send_load(s, 1'b0);
        do_reset(1'b1);
        expect_word(10'd0, 32'hDEAD_BEEF);
        s = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_load(s, 1'b1);
        check_final(1'b1, 1'b0, 1);

        // Two-word program with random valid gaps
        do_reset(1'b0);
        gap_en = 1'b1;
        expect_word(10'd0, 32'h0010_0513);
        expect_word(10'd1, 32'h0020_0593);
        s = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        send_load(s, 1'b1);
        gap_en = 1'b0;
        check_final(1'b1, 1'b0, 2);

        // Reset coinciding with the 4th payload byte suppresses the write
        do_reset(1'b0);
        s = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC};
        send_load(s, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'hDD;
        reset    = 1'b1;
        @(posedge clk); #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("suppressed_we_count", 64'(wr_count), 64'd0);
        check_reset_state();

        // Full-depth image ends at address DEPTH-1
        do_reset(1'b0);
        s = '{8'h00, 8'h04};
        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom;
            expect_word(10'(i), w);
            s.push_back(w[7:0]);
            s.push_back(w[15:8]);
            s.push_back(w[23:16]);
            s.push_back(w[31:24]);
        end
        send_load(s, 1'b1);
        check_final(1'b1, 1'b0, DEPTH);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Explicit checksum byte: correct, then wrong
        do_reset(1'b0);
        expect_word(10'd0, 32'h0010_0513);
        s = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h07};
        send_load(s, 1'b0);
        check_final(1'b1, 1'b0, 1);

        do_reset(1'b0);
        expect_word(10'd0, 32'h0010_0513);
        s = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h08};
        send_load(s, 1'b0);
        check_final(1'b0, 1'b1, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning instruction memory size in 32-bit words.
REQ-002 SHALL have parameter ADDR_W, default 10, meaning word-address width (log2 DEPTH).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on posedge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  byte-stream source has a byte.
REQ-006 SHALL have port in_data  input  8  byte-stream payload.
REQ-007 SHALL have port in_ready  output  1  loader accepts a byte this cycle.
REQ-008 SHALL have port mem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-009 SHALL have port mem_addr  output  ADDR_W  instruction-memory word address.
REQ-010 SHALL have port mem_wdata  output  32  instruction word to write.
REQ-011 SHALL have port cpu_hold  output  1  holds the CPU in reset until a load completes.
REQ-012 SHALL have port done  output  1  load completed successfully.
REQ-013 SHALL have port error  output  1  load aborted (bad length or checksum).

Function
REQ-014 Byte transfer SHALL occur on any posedge where in_valid and in_ready are both 1; in_data is ignored otherwise.
REQ-015 Stream format SHALL be: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N payload bytes, then (only with REQ-031) one checksum byte.
REQ-016 States SHALL be: S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR.
REQ-017 in_ready SHALL be 1 in S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, and 0 in S_DONE and S_ERR.
REQ-018 S_LEN_LO SHALL store byte as N[7:0] and go to S_LEN_HI on transfer.
REQ-019 S_LEN_HI SHALL store N[15:8]; if N > DEPTH go to S_ERR; else if N == 0 go to S_CSUM (macro on) or S_DONE (macro off); else go to S_DATA.
REQ-020 In S_DATA, payload bytes SHALL be packed little-endian: 1st byte -> mem_wdata[7:0], 4th -> [31:24].
REQ-021 On the transfer of each 4th payload byte, mem_we SHALL be 1 for exactly the following cycle, with mem_wdata holding the complete word and mem_addr holding the word index (0 for first word).
REQ-022 mem_addr SHALL increment by 1 after each write; last write of a load of N words SHALL use address N-1; address SHALL never wrap (N <= DEPTH guarantees this, N == DEPTH ends at DEPTH-1).
REQ-023 After the N-th word's 4th byte, state SHALL go to S_CSUM (macro on) or S_DONE (macro off).
REQ-024 Gaps (in_valid low) SHALL be tolerated in any accepting state without affecting byte position or state.
REQ-025 cpu_hold SHALL be 1 in every state except S_DONE; done SHALL be 1 only in S_DONE; error SHALL be 1 only in S_ERR.
REQ-026 S_DONE and S_ERR SHALL be terminal until reset; words already written before S_ERR are not retracted.

Reset
REQ-027 reset SHALL be sampled only at posedge clk and SHALL dominate any simultaneous transfer.
REQ-028 After reset: state S_LEN_LO, in_ready 1, mem_we 0, mem_addr 0, mem_wdata 0, cpu_hold 1, done 0, error 0, byte-position counter 0, checksum accumulator 0.
REQ-029 reset asserted mid-load SHALL abandon the load; the next transfer after reset is treated as LEN_LO.
REQ-030 A pending mem_we SHALL be suppressed if reset is asserted in the cycle it would appear.

Configuration
REQ-031 With macro IMEM_LOADER_CHECKSUM_EN defined, the loader SHALL XOR-accumulate every accepted byte (LEN_LO through last payload byte) and, in S_CSUM, compare the next byte: equal -> S_DONE, unequal -> S_ERR.
REQ-032 Without IMEM_LOADER_CHECKSUM_EN, S_CSUM and the accumulator SHALL not exist and no trailing byte is consumed; the byte after the last payload byte is not accepted (in_ready 0).

Verification
REQ-033 Macro off, stream 02 00 13 05 10 00 93 05 20 00 -> writes addr0=0x00100513, addr1=0x00200593, one mem_we cycle each, then done=1, cpu_hold=0, in_ready=0.
REQ-034 Stream 01 04 (N=1025, DEPTH=1024) -> error=1, cpu_hold=1, zero writes, in_ready=0.
REQ-035 Macro off, stream 00 00 -> done=1 after second byte, no mem_we.
REQ-036 Macro on, stream 01 00 13 05 10 00 then 07 -> one write 0x00100513 to addr0, done=1; same stream with final byte 08 -> error=1.
REQ-037 Send 01 00 13 05, assert reset one cycle, then send 01 00 EF BE AD DE -> single write addr0=0xDEADBEEF, done=1 (macro off).
REQ-038 Randomized in_valid gaps on the REQ-033 stream -> identical writes and final state.
